// File: rtl/usb2_ts_packer_if.sv
// TS byte stream in, EP3 endpoint-buffer write/commit port out.
// The master side is the packer and the slave side is the source/endpoint environment.
interface usb2_ts_packer_if;
  logic [7:0]  ts_data;
  logic        ts_valid;
  logic        ts_start;
  logic        buf_in_ready;
  logic        buf_in_commit_ack;
  logic [10:0] buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_commit;
  logic [10:0] buf_in_commit_len;
  logic [15:0] drop_cnt;
  logic        sync_err;

  modport master (
    input  ts_data, ts_valid, ts_start, buf_in_ready, buf_in_commit_ack,
    output buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len, drop_cnt, sync_err
  );

  modport slave (
    output ts_data, ts_valid, ts_start, buf_in_ready, buf_in_commit_ack,
    input  buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit,
           buf_in_commit_len, drop_cnt, sync_err
  );
endinterface

// File: rtl/usb2_ts_packer.sv
// Packs 188-byte TS packets into EP3 isochronous IN buffers.
// A transfer is committed on a full buffer or after an idle timeout.
module usb2_ts_packer #(
  parameter int unsigned PKTS_PER_XFER = 5,
  parameter logic [15:0] FLUSH_TIMEOUT = 16'd8000
) (
  input logic            ext_clk,
  input logic            reset,
  usb2_ts_packer_if.master bus
);
  localparam int unsigned CW = $clog2(PKTS_PER_XFER + 1);
  localparam logic [CW-1:0] PKTS_MAX = CW'(PKTS_PER_XFER);

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_COMMIT, ST_ACKLO} state_e;

  state_e      state_q, state_d;
  logic [10:0] base_q, base_d;
  logic [7:0]  idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wren_q, wren_d;
  logic        commit_q, commit_d;
  logic [10:0] len_q, len_d;
  logic [15:0] drop_q, drop_d;
  logic        sync_err_q, sync_err_d;

  logic        pkt_open;
  logic        is_start;
  logic        go_commit;
  logic [1:0]  drops;
  logic [16:0] drop_sum;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    timer_d    = timer_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    commit_d   = commit_q;
    len_d      = len_q;
    sync_err_d = 1'b0;
    drops      = '0;

    // A packet is open exactly while byte_idx is non-zero.
    pkt_open  = (idx_q != '0);
    is_start  = bus.ts_valid & bus.ts_start;
    go_commit = (state_q == ST_FILL) &&
                ((cnt_q == PKTS_MAX) || ((cnt_q != '0) && (timer_q >= FLUSH_TIMEOUT)));

    case (state_q)
      ST_IDLE: if (bus.buf_in_ready) state_d = ST_FILL;
      ST_FILL: begin
        if (go_commit) begin
          state_d  = ST_COMMIT;
          commit_d = 1'b1;
          len_d    = base_q;
        end else if ((cnt_q != '0) && !pkt_open) begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_COMMIT: begin
        if (bus.buf_in_commit_ack) begin
          commit_d = 1'b0;
          base_d   = '0;
          cnt_d    = '0;
          timer_d  = '0;
          state_d  = ST_ACKLO;
        end
      end
      ST_ACKLO: if (!bus.buf_in_commit_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Truncation or loss of buffer readiness discards the open packet first;
    // a new start byte is then evaluated on its own merits in the same cycle.
    if (pkt_open && (is_start || !bus.buf_in_ready)) begin
      idx_d = '0;
      drops = drops + 2'd1;
    end

    if (is_start) begin
      if (bus.ts_data != 8'h47) begin
        sync_err_d = 1'b1;
      end else if ((state_q != ST_FILL) || !bus.buf_in_ready || go_commit) begin
        drops = drops + 2'd1;
      end else begin
        addr_d = base_q;
        data_d = bus.ts_data;
        wren_d = 1'b1;
        idx_d  = 8'd1;
      end
    end else if (bus.ts_valid && pkt_open && bus.buf_in_ready) begin
      addr_d = base_q + {3'b000, idx_q};
      data_d = bus.ts_data;
      wren_d = 1'b1;
      if (idx_q == 8'd187) begin
        idx_d   = '0;
        base_d  = base_q + 11'd188;
        cnt_d   = cnt_q + 1'b1;
        timer_d = '0;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end

    drop_sum = {1'b0, drop_q} + {15'd0, drops};
    drop_d   = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      timer_q    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      commit_q   <= 1'b0;
      len_q      <= '0;
      drop_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      timer_q    <= timer_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      commit_q   <= commit_d;
      len_q      <= len_d;
      drop_q     <= drop_d;
      sync_err_q <= sync_err_d;
    end
  end

  assign bus.buf_in_addr       = addr_q;
  assign bus.buf_in_data       = data_q;
  assign bus.buf_in_wren       = wren_q;
  assign bus.buf_in_commit     = commit_q;
  assign bus.buf_in_commit_len = len_q;
  assign bus.drop_cnt          = drop_q;
  assign bus.sync_err          = sync_err_q;
endmodule

// File: tb/tb_usb2_ts_packer.sv
// Randomized bench for usb2_ts_packer: packet-level reference model of the
// committed buffer image, commit length and drop count.
module tb_usb2_ts_packer;
  localparam int unsigned TO_N = 400;
  typedef logic [7:0] pkt_t [0:187];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb2_ts_packer_if bus();

  usb2_ts_packer #(.PKTS_PER_XFER(5), .FLUSH_TIMEOUT(16'(TO_N))) dut (
    .ext_clk(clk),
    .reset  (rst),
    .bus    (bus.master)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Observed endpoint side
  logic [7:0]  mem [0:1023];
  int unsigned wr_cnt = 0, sync_cnt = 0, commit_cnt = 0, hold_cycles = 0;
  int unsigned cyc = 0, last_wr_cyc = 0, commit_cyc = 0;
  logic [10:0] commit_len_seen = '0;
  logic        len_moved = 1'b0;
  logic        commit_prev = 1'b0;
  int unsigned ack_delay = 2;

  // Reference model: image of whole accepted packets and expected drop total
  logic [7:0]  exp_img [0:1023];
  int unsigned exp_len = 0;
  int unsigned exp_drop = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.buf_in_wren) begin
        mem[bus.buf_in_addr[9:0]] <= bus.buf_in_data;
        wr_cnt      <= wr_cnt + 1;
        last_wr_cyc <= cyc;
      end
      if (bus.sync_err) sync_cnt <= sync_cnt + 1;
      if (bus.buf_in_commit) begin
        if (!commit_prev) begin
          commit_cnt      <= commit_cnt + 1;
          commit_len_seen <= bus.buf_in_commit_len;
          commit_cyc      <= cyc;
          hold_cycles     <= 1;
          len_moved       <= 1'b0;
        end else begin
          hold_cycles <= hold_cycles + 1;
          if (bus.buf_in_commit_len !== commit_len_seen) len_moved <= 1'b1;
        end
      end
      commit_prev <= bus.buf_in_commit;
    end else begin
      commit_prev <= 1'b0;
    end
  end

  // Endpoint acknowledge responder
  initial begin
    bus.buf_in_commit_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.buf_in_commit === 1'b1) begin
        repeat (ack_delay) @(negedge clk);
        bus.buf_in_commit_ack = 1'b1;
        for (int i = 0; i < 8 && bus.buf_in_commit === 1'b1; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        bus.buf_in_commit_ack = 1'b0;
      end
    end
  end

  task automatic drive(input logic [7:0] d, input logic s, input logic v);
    bus.ts_data  = d;
    bus.ts_start = s;
    bus.ts_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(8'($urandom), 1'($urandom), 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic gen_pkt(output pkt_t p);
    p[0] = 8'h47;
    for (int i = 1; i < 188; i++) p[i] = 8'($urandom);
  endtask

  task automatic send_pkt(input pkt_t p, input int unsigned nbytes, input int unsigned max_gap);
    for (int unsigned i = 0; i < nbytes; i++) begin
      drive(p[i], (i == 0), 1'b1);
      if (max_gap != 0 && i + 1 < nbytes) idle($urandom_range(0, max_gap));
    end
    bus.ts_valid = 1'b0;
    bus.ts_start = 1'b0;
  endtask

  task automatic model_clear();
    exp_len = 0;
  endtask

  task automatic model_accept(input pkt_t p);
    for (int unsigned i = 0; i < 188; i++) exp_img[exp_len + i] = p[i];
    exp_len += 188;
  endtask

  function automatic int first_bad();
    int bad = -1;
    for (int i = 0; i < int'(exp_len); i++)
      if (bad < 0 && mem[i] !== exp_img[i]) bad = i;
    return bad;
  endfunction

  task automatic wait_commit(input int unsigned prev, input int unsigned budget, output logic ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget && !ok; i++) begin
      tick();
      if (commit_cnt > prev) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    tick();
    n_cmp++; if (bus.buf_in_addr !== 11'd0) begin n_err++; $display("FAIL rst_addr got %0h want 0", bus.buf_in_addr); end
    n_cmp++; if (bus.buf_in_data !== 8'd0) begin n_err++; $display("FAIL rst_data got %0h want 0", bus.buf_in_data); end
    n_cmp++; if (bus.buf_in_wren !== 1'b0) begin n_err++; $display("FAIL rst_wren got %b want 0", bus.buf_in_wren); end
    n_cmp++; if (bus.buf_in_commit !== 1'b0) begin n_err++; $display("FAIL rst_commit got %b want 0", bus.buf_in_commit); end
    n_cmp++; if (bus.buf_in_commit_len !== 11'd0) begin n_err++; $display("FAIL rst_len got %0d want 0", bus.buf_in_commit_len); end
    n_cmp++; if (bus.drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d want 0", bus.drop_cnt); end
    n_cmp++; if (bus.sync_err !== 1'b0) begin n_err++; $display("FAIL rst_sync got %b want 0", bus.sync_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_back_to_back();
    pkt_t p;
    int unsigned w0, c0;
    logic ok;
    int bad;
    idle(10);
    model_clear();
    w0 = wr_cnt;
    c0 = commit_cnt;
    for (int k = 0; k < 5; k++) begin
      gen_pkt(p);
      model_accept(p);
      send_pkt(p, 188, 0);
    end
    wait_commit(c0, 50, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_commit got none want commit"); end
    n_cmp++; if (commit_len_seen !== 11'(exp_len)) begin n_err++; $display("FAIL b2b_len got %0d want %0d", commit_len_seen, exp_len); end
    n_cmp++; if (wr_cnt - w0 !== 940) begin n_err++; $display("FAIL b2b_writes got %0d want 940", wr_cnt - w0); end
    bad = first_bad();
    n_cmp++; if (bad !== -1) begin n_err++; $display("FAIL b2b_image bad byte at %0d got %02h want %02h", bad, mem[bad], exp_img[bad]); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL b2b_drop got %0d want %0d", bus.drop_cnt, exp_drop); end
    idle(15);
  endtask

  task automatic test_timeout();
    pkt_t p;
    int unsigned c0;
    logic ok;
    int bad;
    idle(10);
    model_clear();
    c0 = commit_cnt;
    for (int k = 0; k < 2; k++) begin
      gen_pkt(p);
      model_accept(p);
      send_pkt(p, 188, 2);
      idle($urandom_range(0, 3));
    end
    wait_commit(c0, TO_N + 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL to_commit got none want commit"); end
    n_cmp++; if (commit_len_seen !== 11'd376) begin n_err++; $display("FAIL to_len got %0d want 376", commit_len_seen); end
    n_cmp++; if (commit_cyc - last_wr_cyc !== TO_N + 1) begin n_err++; $display("FAIL to_delay got %0d want %0d", commit_cyc - last_wr_cyc, TO_N + 1); end
    bad = first_bad();
    n_cmp++; if (bad !== -1) begin n_err++; $display("FAIL to_image bad byte at %0d got %02h want %02h", bad, mem[bad], exp_img[bad]); end
    idle(15);
  endtask

  task automatic test_truncation(input int unsigned cut);
    pkt_t p;
    int unsigned w0, c0;
    logic ok;
    int bad;
    idle(10);
    model_clear();
    w0 = wr_cnt;
    c0 = commit_cnt;
    gen_pkt(p); model_accept(p); send_pkt(p, 188, 2);
    gen_pkt(p); exp_drop++;      send_pkt(p, cut, 2);
    gen_pkt(p); model_accept(p); send_pkt(p, 188, 2);
    wait_commit(c0, TO_N + 60, ok);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL trunc_commit cut=%0d got none want commit", cut); end
    n_cmp++; if (commit_len_seen !== 11'(exp_len)) begin n_err++; $display("FAIL trunc_len cut=%0d got %0d want %0d", cut, commit_len_seen, exp_len); end
    n_cmp++; if (wr_cnt - w0 !== 376 + cut) begin n_err++; $display("FAIL trunc_writes cut=%0d got %0d want %0d", cut, wr_cnt - w0, 376 + cut); end
    bad = first_bad();
    n_cmp++; if (bad !== -1) begin n_err++; $display("FAIL trunc_image cut=%0d bad byte at %0d got %02h want %02h", cut, bad, mem[bad], exp_img[bad]); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL trunc_drop got %0d want %0d", bus.drop_cnt, exp_drop); end
    idle(15);
  endtask

  task automatic test_not_ready();
    pkt_t p;
    int unsigned w0, c0;
    idle(10);
    w0 = wr_cnt;
    c0 = commit_cnt;
    bus.buf_in_ready = 1'b0;
    idle(3);
    for (int k = 0; k < 3; k++) begin
      gen_pkt(p);
      exp_drop++;
      send_pkt(p, 188, 1);
    end
    idle(20);
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL nr_writes got %0d want 0", wr_cnt - w0); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL nr_drop got %0d want %0d", bus.drop_cnt, exp_drop); end
    n_cmp++; if (commit_cnt - c0 !== 0) begin n_err++; $display("FAIL nr_commit got %0d want 0", commit_cnt - c0); end
    bus.buf_in_ready = 1'b1;
    idle(5);
  endtask

  task automatic test_sync_err();
    pkt_t p;
    int unsigned w0, s0, c0;
    logic ok;
    int bad;
    idle(10);
    w0 = wr_cnt;
    s0 = sync_cnt;
    gen_pkt(p);
    p[0] = 8'hB8;
    send_pkt(p, 188, 0);
    idle(3);
    n_cmp++; if (sync_cnt - s0 !== 1) begin n_err++; $display("FAIL sync_pulses got %0d want 1", sync_cnt - s0); end
    n_cmp++; if (wr_cnt - w0 !== 0) begin n_err++; $display("FAIL sync_writes got %0d want 0", wr_cnt - w0); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL sync_drop got %0d want %0d", bus.drop_cnt, exp_drop); end
    model_clear();
    c0 = commit_cnt;
    gen_pkt(p);
    model_accept(p);
    send_pkt(p, 188, 1);
    wait_commit(c0, TO_N + 60, ok);
    n_cmp++; if (commit_len_seen !== 11'd188 || ok !== 1'b1) begin n_err++; $display("FAIL sync_len got %0d (seen %b) want 188", commit_len_seen, ok); end
    bad = first_bad();
    n_cmp++; if (bad !== -1) begin n_err++; $display("FAIL sync_image bad byte at %0d got %02h want %02h", bad, mem[bad], exp_img[bad]); end
    idle(15);
  endtask

  task automatic test_commit_hold();
    pkt_t p;
    int unsigned c0;
    logic ok, low;
    idle(10);
    ack_delay = 50;
    model_clear();
    c0 = commit_cnt;
    for (int k = 0; k < 5; k++) begin
      gen_pkt(p);
      model_accept(p);
      send_pkt(p, 188, 0);
    end
    wait_commit(c0, 50, ok);
    for (int k = 0; k < 2; k++) begin
      gen_pkt(p);
      exp_drop++;
      send_pkt(p, 10, 0);
    end
    low = 1'b0;
    for (int i = 0; i < 200 && !low; i++) begin
      tick();
      if (bus.buf_in_commit === 1'b0) low = 1'b1;
    end
    tick();
    n_cmp++; if (ok !== 1'b1 || low !== 1'b1) begin n_err++; $display("FAIL hold_commit got seen=%b released=%b want 1/1", ok, low); end
    n_cmp++; if ((hold_cycles >= 50) !== 1'b1) begin n_err++; $display("FAIL hold_cycles got %0d want >=50", hold_cycles); end
    n_cmp++; if (len_moved !== 1'b0) begin n_err++; $display("FAIL hold_len_stable got moved want stable"); end
    n_cmp++; if (commit_len_seen !== 11'd940) begin n_err++; $display("FAIL hold_len got %0d want 940", commit_len_seen); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL hold_drop got %0d want %0d", bus.drop_cnt, exp_drop); end
    ack_delay = 2;
    idle(15);
  endtask

  task automatic test_reset_abort();
    pkt_t p;
    int unsigned c0;
    idle(10);
    c0 = commit_cnt;
    for (int k = 0; k < 2; k++) begin
      gen_pkt(p);
      send_pkt(p, 188, 0);
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    exp_drop = 0;
    idle(TO_N + 40);
    n_cmp++; if (commit_cnt - c0 !== 0) begin n_err++; $display("FAIL abort_commit got %0d want 0", commit_cnt - c0); end
    n_cmp++; if (bus.drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL abort_drop got %0d want 0", bus.drop_cnt); end
  endtask

  initial begin
    rst              = 1'b1;
    bus.ts_valid     = 1'b0;
    bus.ts_start     = 1'b0;
    bus.ts_data      = 8'h00;
    bus.buf_in_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_timeout();
    test_truncation(100);
    test_truncation($urandom_range(1, 187));
    test_not_ready();
    test_sync_err();
    test_commit_hold();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
